rx_frame_decoder: RTL and testbench

Serial front end of the HDLC receive channel: samples the `Rx` line once per clock, detects flags (0111_1110) and abort patterns (0111_1111), removes inserted zeros, and assembles destuffed bits into bytes. It sits between the `Rx` pin and the Rx controller/buffer logic. It produces the per-byte strobe and data plus the frame-level events that the buffer, FCS checker and status register consume.

---
 rtl/hdlc_pkg.sv | 18 +
 rtl/rx_destuff.sv | 78 +++++++
 rtl/rx_frame_decoder.sv | 159 +++++++++++++++
 tb/tb_rx_frame_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : hdlc_pkg
// Brief  : Shared HDLC receive constants and receiver state encoding
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package hdlc_pkg;

    localparam logic [7:0] FLAG      = 8'h7E;
    localparam logic [7:0] ABORT_WIN = 8'hFE;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } rx_state_t;

endpackage : hdlc_pkg
`default_nettype wire

// File: rtl/rx_destuff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rx_destuff
// Brief  : Drops HDLC stuffed zeros and assembles the remaining bits into bytes
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module rx_destuff
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_tapBit,
    input  logic       i_tapValid,
    input  logic       i_clear,
    output logic [7:0] o_data,
    output logic       o_newByte,
    output logic [2:0] o_bitCnt,
    output logic [7:0] o_byteCnt
);

    logic [2:0] r_onesCnt;
    logic [2:0] r_bitCnt;
    logic [7:0] r_byteCnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_newByte;

    logic       w_drop;
    logic [7:0] w_shiftNext;

    // A zero right after five ones was inserted by the transmitter.
    assign w_drop      = (r_onesCnt == 3'd5) && !i_tapBit;
    assign w_shiftNext = {i_tapBit, r_shift[7:1]};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_onesCnt <= 3'd0;
            r_bitCnt  <= 3'd0;
            r_byteCnt <= 8'd0;
            r_shift   <= 8'd0;
            r_data    <= 8'd0;
            r_newByte <= 1'b0;
        end else begin
            r_newByte <= 1'b0;
            if (i_clear) begin
                r_onesCnt <= 3'd0;
                r_bitCnt  <= 3'd0;
                r_byteCnt <= 8'd0;
            end else if (i_tapValid) begin
                if (w_drop) begin
                    r_onesCnt <= 3'd0;
                end else begin
                    r_shift  <= w_shiftNext;
                    r_bitCnt <= r_bitCnt + 3'd1;
                    if (!i_tapBit) begin
                        r_onesCnt <= 3'd0;
                    end else if (r_onesCnt != 3'd5) begin
                        r_onesCnt <= r_onesCnt + 3'd1;
                    end
                    if (r_bitCnt == 3'd7) begin
                        r_data    <= w_shiftNext;
                        r_newByte <= 1'b1;
                        if (r_byteCnt != 8'hFF) begin
                            r_byteCnt <= r_byteCnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign o_data    = r_data;
    assign o_newByte = r_newByte;
    assign o_bitCnt  = r_bitCnt;
    assign o_byteCnt = r_byteCnt;

endmodule : rx_destuff
`default_nettype wire

// File: rtl/rx_frame_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rx_frame_decoder
// Brief  : HDLC receive front end: flag/abort detection, destuffing, framing
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module rx_frame_decoder
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_AbortSignal,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);

    logic [7:0] r_win;
    logic       r_flagDet;
    logic       r_abortDet;
    logic       r_tapBit;
    logic       r_tapValid;
    logic [2:0] r_skipCnt;
    rx_state_t  r_state;
    logic       r_eof;
    logic       r_abortSig;
    logic       r_frameErr;

    logic       w_flagMatch;
    logic       w_abortMatch;
    rx_state_t  w_nextState;
    logic       w_eof;
    logic       w_abortSig;
    logic       w_frameErr;
    logic       w_restart;
    logic       w_destuffValid;
    logic [2:0] w_bitCnt;
    logic [7:0] w_byteCnt;

    assign w_flagMatch  = (r_win == FLAG);
    assign w_abortMatch = (r_win == ABORT_WIN);

    // The bit leaving on a match edge is the pattern's first bit, so the
    // discard window starts on that edge and covers seven more.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_win      <= 8'hFF;
            r_flagDet  <= 1'b0;
            r_abortDet <= 1'b0;
            r_tapBit   <= 1'b1;
            r_tapValid <= 1'b0;
            r_skipCnt  <= 3'd0;
        end else if (RxEN) begin
            r_win      <= {Rx, r_win[7:1]};
            r_flagDet  <= w_flagMatch;
            r_abortDet <= w_abortMatch;
            r_tapBit   <= r_win[0];
            if (w_flagMatch || w_abortMatch) begin
                r_tapValid <= 1'b0;
                r_skipCnt  <= 3'd7;
            end else if (r_skipCnt != 3'd0) begin
                r_tapValid <= 1'b0;
                r_skipCnt  <= r_skipCnt - 3'd1;
            end else begin
                r_tapValid <= 1'b1;
            end
        end else begin
            r_win      <= 8'hFF;
            r_flagDet  <= 1'b0;
            r_abortDet <= 1'b0;
            r_tapValid <= 1'b0;
            r_skipCnt  <= 3'd0;
        end
    end

    assign w_destuffValid = r_tapValid && (r_state == FRAME);

    rx_destuff u_destuff (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_tapBit   (r_tapBit),
        .i_tapValid (w_destuffValid),
        .i_clear    (w_restart),
        .o_data     (Rx_Data),
        .o_newByte  (Rx_NewByte),
        .o_bitCnt   (w_bitCnt),
        .o_byteCnt  (w_byteCnt)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= HUNT;
            r_eof      <= 1'b0;
            r_abortSig <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_eof      <= w_eof;
            r_abortSig <= w_abortSig;
            r_frameErr <= w_frameErr;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_eof       = 1'b0;
        w_abortSig  = 1'b0;
        w_frameErr  = r_frameErr;
        w_restart   = 1'b0;
        if (!RxEN) begin
            w_nextState = HUNT;
            w_frameErr  = 1'b0;
        end else begin
            case (r_state)
                HUNT: begin
                    w_frameErr = 1'b0;
                    if (r_flagDet) begin
                        w_nextState = FRAME;
                        w_restart   = 1'b1;
                    end
                end
                FRAME: begin
                    if (r_abortDet) begin
                        w_abortSig  = 1'b1;
                        w_nextState = HUNT;
                        w_frameErr  = 1'b0;
                    end else if (r_flagDet) begin
                        // A closing flag doubles as the next opening flag.
                        w_restart = 1'b1;
                        if ((w_byteCnt == 8'd0) && (w_bitCnt == 3'd0)) begin
                            w_frameErr = 1'b0;
                        end else begin
                            w_eof      = 1'b1;
                            w_frameErr = (w_bitCnt != 3'd0);
                        end
                    end
                end
                default: begin
                    w_nextState = HUNT;
                end
            endcase
        end
    end

    assign Rx_FlagDetect  = r_flagDet;
    assign Rx_AbortDetect = r_abortDet;
    assign Rx_ValidFrame  = (r_state == FRAME);
    assign Rx_AbortSignal = r_abortSig;
    assign Rx_EoF         = r_eof;
    assign Rx_FrameError  = r_frameErr;

endmodule : rx_frame_decoder
`default_nettype wire

// File: tb/tb_rx_frame_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_rx_frame_decoder
// Brief  : Directed self-checking bench for rx_frame_decoder
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_rx_frame_decoder;
    import hdlc_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       RxEN;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic       Rx_AbortSignal;
    logic       Rx_EoF;
    logic       Rx_FrameError;

    int         errors = 0;
    int         checks = 0;
    int         eofCnt = 0;
    int         abortCnt = 0;
    logic       lastEofErr = 1'b0;
    logic [7:0] byteLog[$];

    // Outputs captured at the negedge on which the next Rx bit is driven.
    logic [7:0] s_data;
    logic       s_newByte, s_flag, s_abort, s_valid, s_abortSig, s_eof, s_err;

    always #5 Clk = ~Clk;

    rx_frame_decoder dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx             (Rx),
        .RxEN           (RxEN),
        .Rx_Data        (Rx_Data),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameError  (Rx_FrameError)
    );

    always @(negedge Clk) begin
        if (Rx_NewByte) byteLog.push_back(Rx_Data);
        if (Rx_EoF) begin
            eofCnt++;
            lastEofErr = Rx_FrameError;
        end
        if (Rx_AbortSignal) abortCnt++;
    end

    task automatic sendBit(input logic b);
        @(negedge Clk);
        s_data     = Rx_Data;
        s_newByte  = Rx_NewByte;
        s_flag     = Rx_FlagDetect;
        s_abort    = Rx_AbortDetect;
        s_valid    = Rx_ValidFrame;
        s_abortSig = Rx_AbortSignal;
        s_eof      = Rx_EoF;
        s_err      = Rx_FrameError;
        Rx         = b;
    endtask

    task automatic sendBits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) sendBit(v[i]);
    endtask

    task automatic rxOff();
        @(negedge Clk);
        RxEN = 1'b0;
        Rx   = 1'b1;
        repeat (3) @(negedge Clk);
        RxEN = 1'b1;
    endtask

    task automatic test_reset();
        Rst  = 1'b0;
        RxEN = 1'b0;
        Rx   = 1'b1;
        repeat (3) @(negedge Clk);
        if ({Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
             Rx_AbortSignal, Rx_EoF, Rx_FrameError} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h nb=%b fd=%b ad=%b vf=%b as=%b eof=%b fe=%b, want all 0",
                     Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
                     Rx_AbortSignal, Rx_EoF, Rx_FrameError);
        end
        checks++;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_flag_detect();
        rxOff();
        sendBits(16'hFFFF, 10);
        sendBits(16'(FLAG), 8);
        sendBit(1'b1);
        if (s_flag !== 1'b0) begin errors++; $display("FAIL flag_k1: got %b want 0", s_flag); end
        checks++;
        sendBit(1'b1);
        if (s_flag !== 1'b1) begin errors++; $display("FAIL flag_k2: got %b want 1", s_flag); end
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL valid_k2: got %b want 0", s_valid); end
        checks++;
        sendBit(1'b1);
        if (s_flag !== 1'b0) begin errors++; $display("FAIL flag_k3: got %b want 0", s_flag); end
        checks++;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL valid_k3: got %b want 1", s_valid); end
        checks++;
    endtask

    task automatic test_frame_bytes();
        int base;
        int e0;
        rxOff();
        sendBits(16'hFFFF, 4);
        sendBits(16'(FLAG), 8);
        base = byteLog.size();
        e0   = eofCnt;
        sendBits(16'h00A5, 8);
        sendBits(16'h003C, 8);
        sendBits(16'(FLAG), 8);
        sendBit(1'b1);
        if (s_newByte !== 1'b0) begin errors++; $display("FAIL nb_k1: got %b want 0", s_newByte); end
        checks++;
        sendBit(1'b1);
        if (s_newByte !== 1'b1 || s_data !== 8'h3C) begin
            errors++; $display("FAIL nb_k2: got nb=%b data=%h want nb=1 data=3c", s_newByte, s_data);
        end
        checks++;
        sendBit(1'b1);
        if (s_eof !== 1'b1 || s_err !== 1'b0) begin
            errors++; $display("FAIL eof_k3: got eof=%b err=%b want eof=1 err=0", s_eof, s_err);
        end
        checks++;
        sendBit(1'b1);
        if (s_eof !== 1'b0) begin errors++; $display("FAIL eof_k4: got %b want 0", s_eof); end
        checks++;
        rxOff();
        if (byteLog.size() - base !== 2) begin
            errors++; $display("FAIL frame_bytecount: got %0d want 2", byteLog.size() - base);
        end else begin
            if (byteLog[base] !== 8'hA5) begin errors++; $display("FAIL frame_byte0: got %h want a5", byteLog[base]); end
            if (byteLog[base+1] !== 8'h3C) begin errors++; $display("FAIL frame_byte1: got %h want 3c", byteLog[base+1]); end
        end
        checks++;
        if (eofCnt - e0 !== 1) begin errors++; $display("FAIL frame_eofcount: got %0d want 1", eofCnt - e0); end
        checks++;
    endtask

    task automatic test_stuffing();
        int base;
        int e0;
        rxOff();
        sendBits(16'hFFFF, 4);
        sendBits(16'(FLAG), 8);
        base = byteLog.size();
        e0   = eofCnt;
        sendBits(16'h01DF, 9);   // FF on the line: 11111 0 111
        sendBits(16'h003E, 9);   // 3E on the line: 0 11111 0 00
        sendBits(16'(FLAG), 8);
        sendBits(16'hFFFF, 4);
        rxOff();
        if (byteLog.size() - base !== 2) begin
            errors++; $display("FAIL stuff_bytecount: got %0d want 2", byteLog.size() - base);
        end else begin
            if (byteLog[base] !== 8'hFF) begin errors++; $display("FAIL stuff_byte0: got %h want ff", byteLog[base]); end
            if (byteLog[base+1] !== 8'h3E) begin errors++; $display("FAIL stuff_byte1: got %h want 3e", byteLog[base+1]); end
        end
        checks++;
        if (eofCnt - e0 !== 1 || lastEofErr !== 1'b0) begin
            errors++; $display("FAIL stuff_eof: got eofs=%0d err=%b want 1 and 0", eofCnt - e0, lastEofErr);
        end
        checks++;
    endtask

    task automatic test_abort();
        int base;
        int e0;
        int a0;
        rxOff();
        sendBits(16'hFFFF, 4);
        sendBits(16'(FLAG), 8);
        base = byteLog.size();
        e0   = eofCnt;
        a0   = abortCnt;
        sendBits(16'h00A5, 8);
        sendBits(16'(ABORT_WIN), 8);
        sendBit(1'b1);
        if (s_abort !== 1'b0) begin errors++; $display("FAIL abort_k1: got %b want 0", s_abort); end
        checks++;
        sendBit(1'b1);
        if (s_abort !== 1'b1 || s_abortSig !== 1'b0 || s_valid !== 1'b1) begin
            errors++; $display("FAIL abort_k2: got ad=%b as=%b vf=%b want 1 0 1", s_abort, s_abortSig, s_valid);
        end
        checks++;
        sendBit(1'b1);
        if (s_abort !== 1'b0 || s_abortSig !== 1'b1 || s_valid !== 1'b0) begin
            errors++; $display("FAIL abort_k3: got ad=%b as=%b vf=%b want 0 1 0", s_abort, s_abortSig, s_valid);
        end
        checks++;
        sendBit(1'b1);
        if (s_abortSig !== 1'b0) begin errors++; $display("FAIL abort_k4: got %b want 0", s_abortSig); end
        checks++;
        sendBits(16'hFFFF, 4);
        if (eofCnt - e0 !== 0 || abortCnt - a0 !== 1) begin
            errors++; $display("FAIL abort_counts: got eofs=%0d aborts=%0d want 0 and 1", eofCnt - e0, abortCnt - a0);
        end
        checks++;
        if (byteLog.size() - base !== 1) begin
            errors++; $display("FAIL abort_bytecount: got %0d want 1", byteLog.size() - base);
        end else if (byteLog[base] !== 8'hA5) begin
            errors++; $display("FAIL abort_byte: got %h want a5", byteLog[base]);
        end
        checks++;
    endtask

    task automatic test_frame_error();
        int e0;
        rxOff();
        sendBits(16'hFFFF, 4);
        sendBits(16'(FLAG), 8);
        e0 = eofCnt;
        sendBits(16'h00A5, 8);
        sendBits(16'h0005, 3);   // 1,0,1 leaves the frame 3 bits off a byte boundary
        sendBits(16'(FLAG), 8);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        if (s_eof !== 1'b1 || s_err !== 1'b1) begin
            errors++; $display("FAIL ferr_k3: got eof=%b err=%b want 1 1", s_eof, s_err);
        end
        checks++;
        sendBit(1'b1);
        if (s_eof !== 1'b0 || s_err !== 1'b1) begin
            errors++; $display("FAIL ferr_hold: got eof=%b err=%b want 0 1", s_eof, s_err);
        end
        checks++;
        sendBits(16'h0007, 4);   // remaining bits of the back-to-back flag
        sendBits(16'hFFFF, 3);
        if (s_err !== 1'b0 || s_valid !== 1'b1 || s_eof !== 1'b0) begin
            errors++; $display("FAIL ferr_clear: got err=%b vf=%b eof=%b want 0 1 0", s_err, s_valid, s_eof);
        end
        checks++;
        rxOff();
        if (eofCnt - e0 !== 1 || lastEofErr !== 1'b1) begin
            errors++; $display("FAIL ferr_eof: got eofs=%0d err=%b want 1 and 1", eofCnt - e0, lastEofErr);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        int base;
        int e0;
        rxOff();
        sendBits(16'hFFFF, 4);
        sendBits(16'(FLAG), 8);
        sendBits(16'h00A5, 8);
        sendBits(16'h0555, 11);
        if (s_data !== 8'hA5 || s_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got data=%h vf=%b want a5 1", s_data, s_valid);
        end
        checks++;
        #2 Rst = 1'b0;
        #1;
        if ({Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
             Rx_AbortSignal, Rx_EoF, Rx_FrameError} !== 15'h0) begin
            errors++;
            $display("FAIL rst_async: got data=%h nb=%b fd=%b ad=%b vf=%b as=%b eof=%b fe=%b, want all 0",
                     Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
                     Rx_AbortSignal, Rx_EoF, Rx_FrameError);
        end
        checks++;
        @(negedge Clk);
        Rst  = 1'b1;
        base = byteLog.size();
        e0   = eofCnt;
        sendBits(16'hFFFF, 10);
        sendBits(16'(FLAG), 8);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        if (s_valid !== 1'b1) begin errors++; $display("FAIL rst_reopen: got vf=%b want 1", s_valid); end
        checks++;
        sendBits(16'h0014, 5);   // bits 3..7 of A5
        sendBits(16'(FLAG), 8);
        sendBits(16'hFFFF, 4);
        rxOff();
        if (eofCnt - e0 !== 1 || lastEofErr !== 1'b0) begin
            errors++; $display("FAIL rst_eof: got eofs=%0d err=%b want 1 and 0", eofCnt - e0, lastEofErr);
        end
        checks++;
        if (byteLog.size() - base !== 1) begin
            errors++; $display("FAIL rst_bytecount: got %0d want 1", byteLog.size() - base);
        end else if (byteLog[base] !== 8'hA5) begin
            errors++; $display("FAIL rst_byte: got %h want a5", byteLog[base]);
        end
        checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_flag_detect();
        test_frame_bytes();
        test_stuffing();
        test_abort();
        test_frame_error();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rx_frame_decoder
`default_nettype wire
